// File: rtl/sliding_window_buffer_if.sv
// sliding_window_buffer_if: command/pixel handshakes and window output of the Sobel window buffer
interface sliding_window_buffer_if #(
    parameter int PIX_W = 8,
    parameter int WIN   = 3
);
    logic                       cmd_valid;
    logic [2:0]                 cmd_op;
    logic                       cmd_ready;
    logic                       pix_valid;
    logic [PIX_W-1:0]           pix_data;
    logic                       pix_ready;
    logic [WIN*WIN*PIX_W-1:0]   win_data;
    logic                       win_valid;
    logic                       done;
    logic                       cmd_err;

    modport master (
        output cmd_valid, cmd_op, pix_valid, pix_data,
        input  cmd_ready, pix_ready, win_data, win_valid, done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, pix_valid, pix_data,
        output cmd_ready, pix_ready, win_data, win_valid, done, cmd_err
    );
endinterface

// File: rtl/sliding_window_buffer.sv
// sliding_window_buffer: WIN x WIN pixel window with full load, one-step shifts and serial refill
module sliding_window_buffer #(
    parameter int PIX_W = 8,
    parameter int WIN   = 3,
    localparam int CNT_W = $clog2(WIN*WIN+1)
) (
    input logic                  clk,
    input logic                  n_rst,
    sliding_window_buffer_if.slave bus
);
    localparam int N     = WIN*WIN;
    localparam int IDX_W = $clog2(N);

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic             win_valid_q;
    logic             done_q;
    logic             err_q;
    logic [PIX_W-1:0] win_q [N];
    logic [PIX_W-1:0] win_d [N];

    logic             cmd_acc;
    logic             pix_acc;
    logic             is_shift;
    logic             cmd_ok;
    logic             cmd_bad;
    logic             last_pix;
    logic [IDX_W-1:0] fill_idx;

    assign bus.cmd_ready = n_rst && state_q == IDLE;
    assign bus.pix_ready = state_q == FILL;
    assign bus.win_valid = win_valid_q;
    assign bus.done      = done_q;
    assign bus.cmd_err   = err_q;

    assign cmd_acc  = bus.cmd_valid && bus.cmd_ready;
    assign pix_acc  = bus.pix_valid && bus.pix_ready;
    assign is_shift = bus.cmd_op inside {3'd1, 3'd2, 3'd3};
    assign cmd_ok   = cmd_acc && (bus.cmd_op == 3'd0 || bus.cmd_op == 3'd4 || (is_shift && win_valid_q));
    assign cmd_bad  = cmd_acc && !cmd_ok;
    assign last_pix = pix_acc && cnt_q == CNT_W'(mode_q == 2'd0 ? N - 1 : WIN - 1);

    // Load fills bottom row first; left/right refill the vacated column bottom-up; down refills row 0
    assign fill_idx = IDX_W'(mode_q == 2'd0 ? (WIN - 1 - int'(cnt_q) / WIN) * WIN + int'(cnt_q) % WIN :
                             mode_q == 2'd1 ? (WIN - 1 - int'(cnt_q)) * WIN + WIN - 1 :
                             mode_q == 2'd2 ? (WIN - 1 - int'(cnt_q)) * WIN :
                                              int'(cnt_q));

    // Next window: apply accepted shift/clear, then the accepted pixel (never both in one cycle)
    always_comb begin
        win_d = win_q;
        if (cmd_ok)
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++)
                    win_d[r*WIN+c] = bus.cmd_op == 3'd1 ? (c == WIN - 1 ? '0 : win_q[r*WIN + (c + 1) % WIN]) :
                                     bus.cmd_op == 3'd2 ? (c == 0 ? '0 : win_q[r*WIN + (c + WIN - 1) % WIN]) :
                                     bus.cmd_op == 3'd3 ? (r == 0 ? '0 : win_q[((r + WIN - 1) % WIN) * WIN + c]) :
                                     bus.cmd_op == 3'd4 ? '0 : win_q[r*WIN+c];
        if (pix_acc)
            win_d[fill_idx] = bus.pix_data;
    end

    // Flatten the window onto the output bus, element i at bits [(i+1)*PIX_W-1 : i*PIX_W]
    always_comb begin
        bus.win_data = '0;
        for (int i = 0; i < N; i++)
            bus.win_data[i*PIX_W +: PIX_W] = win_q[i];
    end

    // Control FSM with registered status pulses and window storage
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            cnt_q       <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < N; i++)
                win_q[i] <= '0;
        end else begin
            win_q  <= win_d;
            done_q <= 1'b0;
            err_q  <= cmd_bad;
            if (cmd_ok) begin
                win_valid_q <= 1'b0;
                if (bus.cmd_op == 3'd4) begin
                    done_q <= 1'b1;
                end else begin
                    state_q <= FILL;
                    mode_q  <= bus.cmd_op[1:0];
                    cnt_q   <= '0;
                end
            end
            if (pix_acc) begin
                if (last_pix) begin
                    cnt_q       <= '0;
                    state_q     <= IDLE;
                    win_valid_q <= 1'b1;
                    done_q      <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/sliding_window_buffer.md
Name: sliding_window_buffer

Overview:
- Parametrised WIN x WIN pixel window register for the Sobel pipeline. Sits between the image memory read controller and the gradient/convolution unit.
- Supports full-window load and one-step left, right or down shifts. After a shift, only the vacated column or row is refilled from a serial pixel stream.
- Uses valid/ready handshakes on both the command and pixel interfaces. Signals completion with a one-cycle pulse and a sticky window-valid flag.

Parameters:
- PIX_W, 8, pixel width in bits.
- WIN, 3, window side length; odd, 3..7.
- CNT_W, $clog2(WIN*WIN+1), fill counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_op  in  3  0=LOAD_FULL, 1=SHIFT_LEFT, 2=SHIFT_RIGHT, 3=SHIFT_DOWN, 4=CLEAR, 5..7 illegal.
- cmd_ready  out  1  high only in IDLE.
- pix_valid  in  1  pixel available.
- pix_data  in  PIX_W  pixel value.
- pix_ready  out  1  high only in FILL.
- win_data  out  WIN*WIN*PIX_W  element (r,c) at index i=r*WIN+c, bits [(i+1)*PIX_W-1 : i*PIX_W]; r=0 is the top row, c=0 is the left column.
- win_valid  out  1  window fully populated.
- done  out  1  one-cycle completion pulse.
- cmd_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (async, n_rst=0):
  - All window elements = 0, state = IDLE, counter = 0.
  - win_valid=0, done=0, cmd_err=0, pix_ready=0, cmd_ready=0 while reset is asserted.
  - On reset deassertion, cmd_ready=1 because the block is in IDLE.
- States: IDLE, FILL. All outputs are registered except cmd_ready and pix_ready, which decode the state.
- Command acceptance = cmd_valid & cmd_ready, sampled at edge t. Effects at edge t:
  - LOAD_FULL: win_valid<=0, counter<=0, go to FILL with expected count WIN*WIN. Existing contents are kept until overwritten.
  - SHIFT_LEFT: every column c takes column c+1; column WIN-1 <= 0; go to FILL with WIN pixels.
  - SHIFT_RIGHT: column c takes column c-1; column 0 <= 0; go to FILL with WIN pixels.
  - SHIFT_DOWN: row r takes row r-1; row 0 <= 0; go to FILL with WIN pixels.
  - All shifts also set win_valid<=0.
  - CLEAR: all elements <= 0, win_valid<=0, done<=1, stay in IDLE.
  - Shift while win_valid=0, or an illegal opcode: cmd_err<=1, window and state unchanged.
- Pixel acceptance = pix_valid & pix_ready. Each accepted pixel is written at edge k, then the counter increments.
- Fill order:
  - LOAD_FULL: rows WIN-1 down to 0, each row left to right. For WIN=3 the index order is 6,7,8,3,4,5,0,1,2.
  - SHIFT_LEFT: column WIN-1, bottom to top (WIN=3: 8,5,2).
  - SHIFT_RIGHT: column 0, bottom to top (6,3,0).
  - SHIFT_DOWN: row 0, left to right (0,1,2).
- Fill completion: on the edge accepting the last pixel, write the pixel, counter<=0, state<=IDLE, win_valid<=1, done<=1.
  - done and cmd_ready are therefore both high in the following cycle, so a back-to-back command may be accepted then.
- Timing:
  - Shift-plus-fill latency = 1 + WIN accepted-pixel cycles.
  - Pixel stalls (pix_valid=0) hold the counter and contents.
- Pixel interface outside FILL: pix_valid in IDLE is ignored and pix_ready=0.
- Command interface outside IDLE: cmd_valid in FILL is not accepted and is held off by cmd_ready=0.
- Pulses: done and cmd_err self-clear after one cycle.
- Reset mid-FILL: the window is cleared immediately and the partial fill is discarded.
- Counter never exceeds WIN*WIN-1; no wrap beyond the expected count.

Test Plan:
- Reset then LOAD_FULL with pixels 1..9 streamed continuously (WIN=3) -> window indices 0..8 = 7,8,9,4,5,6,1,2,3; done and win_valid high 10 cycles after the command edge.
- From that window, SHIFT_LEFT with pixels 10,11,12 -> indices 0..8 = 8,9,12,5,6,11,2,3,10; win_valid low during the fill, high with done afterwards.
- SHIFT_DOWN with pixels 20,21,22, with pix_valid dropped for 2 cycles mid-stream -> new top row 20,21,22, other rows moved down one; done delayed exactly 2 cycles.
- SHIFT_RIGHT immediately after reset, and cmd_op=6 -> cmd_err pulse for each, window all zero, cmd_ready stays 1.
- Assert n_rst=0 after 4 of 9 LOAD_FULL pixels -> all outputs zero asynchronously; a fresh LOAD_FULL then completes normally.
- WIN=5, PIX_W=10 LOAD_FULL of 25 pixels with value 1023 followed by CLEAR -> all elements 1023 with win_valid=1, then all zero with win_valid=0 and done pulsed.
